// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM host arbiter: host identities, index width and the
// one-deep response record that follows every grant.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    TestUtilHost = 2'd0,
    CoreD        = 2'd1,
    CoreI        = 2'd2
  } host_e;

  localparam int NrHostsDefault = 3;
  // Wide enough for up to 16 hosts; the picker and response demux use this width.
  localparam int HostIdxWidth   = 4;

  typedef struct packed {
    logic                    vld;
    logic [HostIdxWidth-1:0] host_idx;
    logic                    err;
  } rsp_state_t;

endpackage

// File: rtl/ram_arb_prio_pick.sv
// Combinational winner selection: starved requesters take precedence over the
// plain static order; within either group the lowest index wins.
module ram_arb_prio_pick
  import ram_arb_pkg::*;
#(
  parameter int NrHosts = NrHostsDefault
) (
  input  logic [NrHosts-1:0]      req,
  input  logic [NrHosts-1:0]      starved,
  output logic [NrHosts-1:0]      gnt,
  output logic [HostIdxWidth-1:0] idx
);

  logic [NrHosts-1:0] cand;

  always_comb begin
    cand = (|(req & starved)) ? (req & starved) : req;
    idx  = '0;
    gnt  = '0;
    // Scan from the top so the last hit is the lowest index.
    for (int i = NrHosts - 1; i >= 0; i--) begin
      if (cand[i]) idx = HostIdxWidth'(i);
    end
    for (int i = 0; i < NrHosts; i++) begin
      gnt[i] = cand[i] && (idx == HostIdxWidth'(i));
    end
  end

endmodule

// File: rtl/ram_host_arbiter.sv
// Shares one single-port RAM among several hosts: same-cycle grant, fixed
// one-cycle response routing, and error responses outside the RAM window.
module ram_host_arbiter
  import ram_arb_pkg::*;
#(
  parameter int                   NrHosts      = NrHostsDefault,
  parameter int                   AddrWidth    = 32,
  parameter int                   DataWidth    = 32,
  parameter int                   RamSizeWords = 16384,
  parameter logic [AddrWidth-1:0] RamBaseAddr  = '0,
  parameter int                   MaxWait      = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NrHosts-1:0]                   host_req_i,
  output logic [NrHosts-1:0]                   host_gnt_o,
  input  logic [NrHosts-1:0][AddrWidth-1:0]    host_addr_i,
  input  logic [NrHosts-1:0]                   host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]  host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]    host_wdata_i,
  output logic [NrHosts-1:0]                   host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]    host_rdata_o,
  output logic [NrHosts-1:0]                   host_err_o,
  output logic                                 ram_req_o,
  output logic                                 ram_we_o,
  output logic [DataWidth/8-1:0]               ram_be_o,
  output logic [AddrWidth-1:0]                 ram_addr_o,
  output logic [DataWidth-1:0]                 ram_wdata_o,
  input  logic                                 ram_rvalid_i,
  input  logic [DataWidth-1:0]                 ram_rdata_i
);

  localparam int                   BeWidth    = DataWidth / 8;
  localparam logic [AddrWidth-1:0] WinMask    = ~AddrWidth'(RamSizeWords * 4 - 1);
  localparam logic [7:0]           MaxWaitCnt = 8'(MaxWait);

  logic [NrHosts-1:0]      starved;
  logic [NrHosts-1:0]      gnt;
  logic [HostIdxWidth-1:0] win_idx;
  logic [AddrWidth-1:0]    win_addr;
  logic [DataWidth-1:0]    win_wdata;
  logic [BeWidth-1:0]      win_be;
  logic                    win_we;
  logic                    any_gnt;
  logic                    in_range;
  rsp_state_t              rsp_q;

  ram_arb_prio_pick #(.NrHosts(NrHosts)) u_pick (
    .req     (host_req_i),
    .starved (starved),
    .gnt     (gnt),
    .idx     (win_idx)
  );

  assign host_gnt_o = gnt;
  assign any_gnt    = |gnt;

  genvar gi;
  generate
    for (gi = 0; gi < NrHosts; gi++) begin : g_host
      logic [7:0] wait_q;

      // Counts cycles spent requesting without a grant; dropping req forgets it.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          wait_q <= '0;
        end else if (!host_req_i[gi] || gnt[gi]) begin
          wait_q <= '0;
        end else if (wait_q != MaxWaitCnt) begin
          wait_q <= wait_q + 8'd1;
        end
      end

      assign starved[gi]       = (wait_q == MaxWaitCnt);
      assign host_rvalid_o[gi] = rsp_q.vld && (rsp_q.host_idx == HostIdxWidth'(gi));
      assign host_err_o[gi]    = host_rvalid_o[gi] && rsp_q.err;
      assign host_rdata_o[gi]  = (host_rvalid_o[gi] && !rsp_q.err) ? ram_rdata_i : '0;
    end
  endgenerate

  // One-hot AND-OR mux of the winning host's request fields.
  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_be    = '0;
    win_we    = 1'b0;
    for (int i = 0; i < NrHosts; i++) begin
      if (gnt[i]) begin
        win_addr  = host_addr_i[i];
        win_wdata = host_wdata_i[i];
        win_be    = host_be_i[i];
        win_we    = host_we_i[i];
      end
    end
  end

  assign in_range    = ((win_addr & WinMask) == RamBaseAddr);
  assign ram_req_o   = any_gnt && in_range;
  assign ram_we_o    = ram_req_o && win_we;
  assign ram_be_o    = ram_req_o ? win_be    : '0;
  assign ram_addr_o  = ram_req_o ? win_addr  : '0;
  assign ram_wdata_o = ram_req_o ? win_wdata : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_q <= '0;
    end else if (any_gnt) begin
      rsp_q <= '{vld: 1'b1, host_idx: win_idx, err: !in_range};
    end else begin
      rsp_q <= '0;
    end
  end

  // The RAM must answer exactly the accesses that were forwarded to it.
  a_ram_rvalid : assert property (@(posedge clk_i) disable iff (rst_i)
    ram_rvalid_i == (rsp_q.vld && !rsp_q.err));

endmodule

// File: tb/tb_ram_host_arbiter.sv
// Directed bench for ram_host_arbiter: a vector table for single-cycle
// behaviour plus hand-written starvation and reset sequences.
module tb_ram_host_arbiter;
  import ram_arb_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       host_req = '0;
  logic [2:0]       host_gnt;
  logic [2:0][31:0] host_addr = '0;
  logic [2:0]       host_we = '0;
  logic [2:0][3:0]  host_be = '0;
  logic [2:0][31:0] host_wdata = '0;
  logic [2:0]       host_rvalid;
  logic [2:0][31:0] host_rdata;
  logic [2:0]       host_err;
  logic             ram_req, ram_we;
  logic [3:0]       ram_be;
  logic [31:0]      ram_addr, ram_wdata;
  logic             ram_rvalid;
  logic [31:0]      ram_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_host_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
    .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
    .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rvalid_i(ram_rvalid), .ram_rdata_i(ram_rdata)
  );

  // Simulation RAM: 64 kB, one-cycle latency, returns the old word on writes.
  bit [31:0] mem [16384];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_rvalid <= 1'b0;
      ram_rdata  <= '0;
    end else begin
      ram_rvalid <= ram_req;
      if (ram_req) begin
        ram_rdata <= mem[ram_addr[15:2]];
        if (ram_we) begin
          for (int b = 0; b < 4; b++) begin
            if (ram_be[b]) mem[ram_addr[15:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  initial begin
    mem[14'h0020] <= 32'h0000_0013;
    mem[14'h0040] <= 32'h1234_5678;
    mem[14'h3FFF] <= 32'hCAFE_F00D;
  end

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  we;
    logic [31:0] a0, a1, a2;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [2:0]  gnt;
    logic        rr;
    logic [2:0]  rv;
    logic [2:0]  er;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(logic [2:0] req, logic [2:0] we, logic [31:0] a0, logic [31:0] a1,
                              logic [31:0] a2, logic [3:0] be, logic [31:0] wd, logic [2:0] gnt,
                              logic rr, logic [2:0] rv, logic [2:0] er, logic [31:0] rd);
    vec_t v;
    v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.be = be; v.wd = wd;
    v.gnt = gnt; v.rr = rr; v.rv = rv; v.er = er; v.rd = rd;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic [2:0] req, logic [2:0] we, logic [31:0] a0, logic [31:0] a1,
                       logic [31:0] a2, logic [3:0] be, logic [31:0] wd);
    host_req = req;
    host_we  = we;
    host_addr[0] = a0; host_addr[1] = a1; host_addr[2] = a2;
    for (int h = 0; h < 3; h++) begin
      host_be[h]    = be;
      host_wdata[h] = wd;
    end
  endtask

  vec_t vecs[17];
  logic [2:0] exp_gnt;

  initial begin
    //                req     we      a0          a1          a2        be      wd            gnt    rr  rv      er      rd
    vecs[0]  = mk(3'b000, 3'b000, 32'h0,      32'h0,      32'h0,   4'hF, 32'h0,        3'b000, 0, 3'b000, 3'b000, 32'h0);
    vecs[1]  = mk(3'b100, 3'b000, 32'h0,      32'h0,      32'h80,  4'hF, 32'h0,        3'b100, 1, 3'b000, 3'b000, 32'h0);
    vecs[2]  = mk(3'b000, 3'b000, 32'h0,      32'h0,      32'h0,   4'hF, 32'h0,        3'b000, 0, 3'b100, 3'b000, 32'h13);
    vecs[3]  = mk(3'b110, 3'b000, 32'h0,      32'h80,     32'h100, 4'hF, 32'h0,        3'b010, 1, 3'b000, 3'b000, 32'h0);
    vecs[4]  = mk(3'b100, 3'b000, 32'h0,      32'h0,      32'h100, 4'hF, 32'h0,        3'b100, 1, 3'b010, 3'b000, 32'h13);
    vecs[5]  = mk(3'b000, 3'b000, 32'h0,      32'h0,      32'h0,   4'hF, 32'h0,        3'b000, 0, 3'b100, 3'b000, 32'h12345678);
    vecs[6]  = mk(3'b010, 3'b010, 32'h0,      32'h20000,  32'h0,   4'hF, 32'hDEADBEEF, 3'b010, 0, 3'b000, 3'b000, 32'h0);
    vecs[7]  = mk(3'b000, 3'b000, 32'h0,      32'h0,      32'h0,   4'hF, 32'h0,        3'b000, 0, 3'b010, 3'b010, 32'h0);
    vecs[8]  = mk(3'b010, 3'b010, 32'h0,      32'h100,    32'h0,   4'h3, 32'hA5A5A5A5, 3'b010, 1, 3'b000, 3'b000, 32'h0);
    vecs[9]  = mk(3'b010, 3'b000, 32'h0,      32'h100,    32'h0,   4'hF, 32'h0,        3'b010, 1, 3'b010, 3'b000, 32'h12345678);
    vecs[10] = mk(3'b000, 3'b000, 32'h0,      32'h0,      32'h0,   4'hF, 32'h0,        3'b000, 0, 3'b010, 3'b000, 32'h1234A5A5);
    vecs[11] = mk(3'b011, 3'b000, 32'h20000,  32'h80,     32'h0,   4'hF, 32'h0,        3'b001, 0, 3'b000, 3'b000, 32'h0);
    vecs[12] = mk(3'b010, 3'b000, 32'h0,      32'h80,     32'h0,   4'hF, 32'h0,        3'b010, 1, 3'b001, 3'b001, 32'h0);
    vecs[13] = mk(3'b000, 3'b000, 32'h0,      32'h0,      32'h0,   4'hF, 32'h0,        3'b000, 0, 3'b010, 3'b000, 32'h13);
    vecs[14] = mk(3'b001, 3'b000, 32'hFFFC,   32'h0,      32'h0,   4'hF, 32'h0,        3'b001, 1, 3'b000, 3'b000, 32'h0);
    vecs[15] = mk(3'b001, 3'b000, 32'h10000,  32'h0,      32'h0,   4'hF, 32'h0,        3'b001, 0, 3'b001, 3'b000, 32'hCAFEF00D);
    vecs[16] = mk(3'b000, 3'b000, 32'h0,      32'h0,      32'h0,   4'hF, 32'h0,        3'b000, 0, 3'b001, 3'b001, 32'h0);

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_rvalid", 32'(host_rvalid), 32'h0);
    check("rst_err", 32'(host_err), 32'h0);
    check("rst_rdata_or", host_rdata[0] | host_rdata[1] | host_rdata[2], 32'h0);
    check("rst_ram_req", 32'(ram_req), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].be, vecs[i].wd);
      #1;
      $display("vec %0d req=%b gnt=%b ram_req=%b rvalid=%b err=%b", i, host_req, host_gnt, ram_req,
               host_rvalid, host_err);
      check($sformatf("v%0d_gnt", i), 32'(host_gnt), 32'(vecs[i].gnt));
      check($sformatf("v%0d_ram_req", i), 32'(ram_req), 32'(vecs[i].rr));
      if (!vecs[i].rr)
        check($sformatf("v%0d_ram_zero", i), ram_addr | ram_wdata | 32'(ram_be) | 32'(ram_we), 32'h0);
      check($sformatf("v%0d_rvalid", i), 32'(host_rvalid), 32'(vecs[i].rv));
      check($sformatf("v%0d_err", i), 32'(host_err), 32'(vecs[i].er));
      for (int h = 0; h < 3; h++)
        check($sformatf("v%0d_rdata%0d", i, h), host_rdata[h], vecs[i].rv[h] ? vecs[i].rd : 32'h0);
    end

    // Starvation: hosts 0 and 1 always request, host 2 joins one cycle later.
    @(negedge clk);
    drive(3'b011, 3'b000, 32'h80, 32'h80, 32'h80, 4'hF, 32'h0);
    #1;
    check("starve_t0_gnt", 32'(host_gnt), 32'h1);
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      drive(3'b111, 3'b000, 32'h80, 32'h80, 32'h80, 4'hF, 32'h0);
      #1;
      exp_gnt = (k == 7 || k == 16) ? 3'b010 : (k == 8 || k == 17) ? 3'b100 : 3'b001;
      $display("starve k=%0d gnt=%b", k, host_gnt);
      check($sformatf("starve_k%0d_gnt", k), 32'(host_gnt), 32'(exp_gnt));
    end
    @(negedge clk);
    drive(3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 4'hF, 32'h0);
    @(negedge clk);

    // Reset in the cycle after a grant, with host 1's counter part-way up.
    drive(3'b011, 3'b000, 32'h80, 32'h80, 32'h0, 4'hF, 32'h0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_rvalid", 32'(host_rvalid), 32'h0);
    @(negedge clk);
    check("midrst_rvalid_hold", 32'(host_rvalid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst_gnt", 32'(host_gnt), 32'h1);
    check("postrst_rvalid", 32'(host_rvalid), 32'h0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1;
      $display("postrst k=%0d gnt=%b", k, host_gnt);
      check($sformatf("postrst_k%0d_gnt", k), 32'(host_gnt), (k == 8) ? 32'h2 : 32'h1);
    end
    @(negedge clk);
    drive(3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 4'hF, 32'h0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
